// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Default widths, arbiter priority state and the hard-wired zero register index.
package reg_write_arbiter_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_CNT_W    = 16;

    // Register x0 reads as zero and is never written.
    localparam int unsigned ZERO_REG_IDX = 0;

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: step on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbiter sharing one register-file write port between the ALU and the load unit.
// Optional macro WB_RR_ARB_EN: round-robin tie breaking; when undefined the
// load unit always wins a tie and the state stays PRI_MEM.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluRegId,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memRegId,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeRegId,
    output logic [DATA_W-1:0] writeData,
    output logic [CNT_W-1:0]  conflictCount
);

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(ZERO_REG_IDX);

    arb_state_e        state_q, state_d;
    logic              mem_wins_tie;
    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] writeRegId_q, writeRegId_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;

    // Grant decode: a lone requester is accepted at once; ties follow the state.
    always_comb begin
        mem_wins_tie = (state_q == PRI_MEM);
        memReady     = resetN & memValid & (~aluValid | mem_wins_tie);
        aluReady     = resetN & aluValid & (~memValid | ~mem_wins_tie);
    end

    // Next state and next write-port contents; x0 transfers are accepted but dropped.
    always_comb begin
        state_d      = state_q;
        regWrite_d   = 1'b0;
        writeRegId_d = writeRegId_q;
        writeData_d  = writeData_q;
`ifdef WB_RR_ARB_EN
        if (aluValid && memValid) begin
            state_d = mem_wins_tie ? PRI_ALU : PRI_MEM;
        end
`else
        state_d = PRI_MEM;
`endif
        if (memReady && (memRegId != ZERO_REG)) begin
            regWrite_d   = 1'b1;
            writeRegId_d = memRegId;
            writeData_d  = memData;
        end else if (aluReady && (aluRegId != ZERO_REG)) begin
            regWrite_d   = 1'b1;
            writeRegId_d = aluRegId;
            writeData_d  = aluData;
        end
    end

    // State and write-port registers; reset discards any pending write.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= PRI_MEM;
            regWrite_q   <= 1'b0;
            writeRegId_q <= '0;
            writeData_q  <= '0;
        end else begin
            state_q      <= state_d;
            regWrite_q   <= regWrite_d;
            writeRegId_q <= writeRegId_d;
            writeData_q  <= writeData_d;
        end
    end

    assign regWrite   = regWrite_q;
    assign writeRegId = writeRegId_q;
    assign writeData  = writeData_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_conflict_cnt (
        .clock  (clock),
        .resetN (resetN),
        .inc    (aluValid & memValid),
        .count  (conflictCount)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter: vector table for single-requester
// traffic, hand sequences for ties, reset and counter saturation.
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic        aluValid, memValid;
    logic [4:0]  aluRegId, memRegId;
    logic [31:0] aluData, memData;
    logic        aluReady, memReady, regWrite;
    logic [4:0]  writeRegId;
    logic [31:0] writeData;
    logic [15:0] conflictCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    reg_write_arbiter #(
        .DATA_W (32),
        .ADDR_W (5),
        .CNT_W  (16)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .aluValid      (aluValid),
        .aluRegId      (aluRegId),
        .aluData       (aluData),
        .aluReady      (aluReady),
        .memValid      (memValid),
        .memRegId      (memRegId),
        .memData       (memData),
        .memReady      (memReady),
        .regWrite      (regWrite),
        .writeRegId    (writeRegId),
        .writeData     (writeData),
        .conflictCount (conflictCount)
    );

    always #5 clock = ~clock;

    // Register file fed by the arbiter's write port.
    always @(posedge clock) begin
        if (regWrite) rf[writeRegId] <= writeData;
    end

    typedef struct {
        logic        aluV;
        logic [4:0]  aluId;
        logic [31:0] aluD;
        logic        memV;
        logic [4:0]  memId;
        logic [31:0] memD;
        logic        eAluR;
        logic        eMemR;
        logic        eRw;
        logic [4:0]  eId;
        logic [31:0] eData;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aid, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mid, input logic [31:0] md);
        aluValid = av; aluRegId = aid; aluData = ad;
        memValid = mv; memRegId = mid; memData = md;
    endtask

    initial begin
        logic        exp_mem [4];
        int          mi, ai;

        for (int r = 0; r < 32; r++) rf[r] = '0;

`ifdef WB_RR_ARB_EN
        exp_mem = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        //            aluV id  data          memV id  data          aR   mR   rw   id  data
        tbl[0] = '{1'b1, 5'd5,  32'd50,       1'b0, 5'd0, 32'h0,       1'b1,1'b0,1'b1,5'd5, 32'd50};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,       1'b0,1'b0,1'b0,5'd5, 32'd50};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hABCD,    1'b0,1'b1,1'b1,5'd7, 32'hABCD};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF,1'b0,1'b1,1'b0,5'd7, 32'hABCD};
        tbl[4] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0, 32'h0,       1'b1,1'b0,1'b0,5'd7, 32'hABCD};
        tbl[5] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b1,1'b0,1'b1,5'd31,32'hDEADBEEF};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,       1'b0,1'b0,1'b0,5'd31,32'hDEADBEEF};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1, 32'h1,       1'b0,1'b1,1'b1,5'd1, 32'h1};

        // Reset with both requesters asserting: nothing may be accepted.
        resetN = 1'b0;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        #2;
        chk("rst_aluReady", 32'(aluReady), 32'd0);
        chk("rst_memReady", 32'(memReady), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_writeRegId", 32'(writeRegId), 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_conflictCount", 32'(conflictCount), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        resetN = 1'b1;
        @(posedge clock); #1;

        // Single-requester vectors, including x0 accepts and idle hold.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].aluV, tbl[i].aluId, tbl[i].aluD, tbl[i].memV, tbl[i].memId, tbl[i].memD);
            @(negedge clock);
            chk($sformatf("vec%0d_aluReady", i), 32'(aluReady), 32'(tbl[i].eAluR));
            chk($sformatf("vec%0d_memReady", i), 32'(memReady), 32'(tbl[i].eMemR));
            @(posedge clock); #1;
            chk($sformatf("vec%0d_regWrite", i), 32'(regWrite), 32'(tbl[i].eRw));
            chk($sformatf("vec%0d_writeRegId", i), 32'(writeRegId), 32'(tbl[i].eId));
            chk($sformatf("vec%0d_writeData", i), writeData, tbl[i].eData);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("tbl_conflictCount", 32'(conflictCount), 32'd0);
        chk("rf_x5", rf[5], 32'd50);
        chk("rf_x0", rf[0], 32'd0);
        chk("rf_x7", rf[7], 32'hABCD);
        chk("rf_x31", rf[31], 32'hDEADBEEF);

        // Tie from PRI_MEM: load first, ALU on the following cycle.
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        @(negedge clock);
        chk("tie1_aluReady", 32'(aluReady), 32'd0);
        chk("tie1_memReady", 32'(memReady), 32'd1);
        @(posedge clock); #1;
        chk("tie1_writeRegId", 32'(writeRegId), 32'd4);
        chk("tie1_writeData", writeData, 32'h22);
        chk("tie1_conflictCount", 32'(conflictCount), 32'd1);
        memValid = 1'b0;
        @(negedge clock);
        chk("tie2_aluReady", 32'(aluReady), 32'd1);
        @(posedge clock); #1;
        chk("tie2_regWrite", 32'(regWrite), 32'd1);
        chk("tie2_writeRegId", 32'(writeRegId), 32'd3);
        chk("tie2_writeData", writeData, 32'h11);
        chk("tie2_conflictCount", 32'(conflictCount), 32'd1);

        // Reset one cycle after a transfer drops the pending write at once.
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        @(posedge clock); #1;
        aluValid = 1'b0;
        chk("pre_rst_regWrite", 32'(regWrite), 32'd1);
        #1 resetN = 1'b0;
        #1;
        chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
        chk("mid_rst_writeRegId", 32'(writeRegId), 32'd0);
        chk("mid_rst_conflictCount", 32'(conflictCount), 32'd0);
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock); #1;

        // Four back-to-back ties; each side presents a fresh request once granted.
        mi = 0;
        ai = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(10 + ai), 32'h200 + 32'(ai), 1'b1, 5'(20 + mi), 32'h100 + 32'(mi));
            @(negedge clock);
            chk($sformatf("rr%0d_memReady", k), 32'(memReady), 32'(exp_mem[k]));
            chk($sformatf("rr%0d_aluReady", k), 32'(aluReady), 32'(!exp_mem[k]));
            @(posedge clock); #1;
            if (exp_mem[k]) begin
                chk($sformatf("rr%0d_writeRegId", k), 32'(writeRegId), 32'(20 + mi));
                chk($sformatf("rr%0d_writeData", k), writeData, 32'h100 + 32'(mi));
                mi++;
            end else begin
                chk($sformatf("rr%0d_writeRegId", k), 32'(writeRegId), 32'(10 + ai));
                chk($sformatf("rr%0d_writeData", k), writeData, 32'h200 + 32'(ai));
                ai++;
            end
        end
        chk("rr_conflictCount", 32'(conflictCount), 32'd4);

        // Hold the tie until the counter saturates.
        repeat (65530) @(posedge clock);
        #1;
        chk("sat_below_max", 32'(conflictCount), 32'h0000FFFE);
        repeat (9) @(posedge clock);
        #1;
        chk("sat_at_max", 32'(conflictCount), 32'h0000FFFF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clock); #1;
        chk("sat_hold", 32'(conflictCount), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: writeback data width.
REQ-002 Parameter ADDR_W, default 5: register index width (32 registers).
REQ-003 Parameter CNT_W, default 16: conflict counter width.
REQ-004 clock  input  1: single clock, all state updates on posedge.
REQ-005 resetN  input  1: asynchronous, active-low reset.
REQ-006 aluValid  input  1: ALU writeback request.
REQ-007 aluRegId  input  ADDR_W: ALU destination register.
REQ-008 aluData  input  DATA_W: ALU result.
REQ-009 aluReady  output  1: ALU request accepted this cycle (combinational).
REQ-010 memValid  input  1: load-unit writeback request.
REQ-011 memRegId  input  ADDR_W: load destination register.
REQ-012 memData  input  DATA_W: load result.
REQ-013 memReady  output  1: load request accepted this cycle (combinational).
REQ-014 regWrite  output  1: register-file write enable (registered).
REQ-015 writeRegId  output  ADDR_W: register-file write index (registered).
REQ-016 writeData  output  DATA_W: register-file write data (registered).
REQ-017 conflictCount  output  CNT_W: saturating count of cycles with both requests valid.

Function
REQ-018 The block SHALL share the single register-file write port between the ALU and load requesters.
REQ-019 Handshake: a request transfers when valid and ready are both 1 on a posedge; at most one transfer per cycle.
REQ-020 A requester's valid, regId and data SHALL be held stable until its ready is 1.
REQ-021 With one valid requester, its ready SHALL be 1 in the same cycle (no bubble).
REQ-022 With no valid requester, both readys SHALL be 0.
REQ-023 A transfer on edge N SHALL drive regWrite=1, writeRegId and writeData for exactly the cycle after edge N (latency 1); otherwise regWrite=0.
REQ-024 writeRegId/writeData SHALL hold their last values while regWrite=0.
REQ-025 A transfer with regId 0 SHALL be accepted (ready=1) but SHALL leave regWrite=0, so x0 is never written.
REQ-026 The arbiter state machine SHALL have states PRI_MEM (load wins a tie) and PRI_ALU (ALU wins a tie).
REQ-027 After a tie resolved in PRI_MEM the state SHALL move to PRI_ALU, and vice versa; a single-requester transfer SHALL leave the state unchanged.
REQ-028 conflictCount SHALL increment on every posedge with aluValid=1 and memValid=1, and SHALL saturate at all-ones.
REQ-029 Both requests valid with the same regId SHALL be served as two separate transfers in arbitration order, with no merging.

Reset
REQ-030 While resetN=0 the outputs SHALL be regWrite=0, writeRegId=0, writeData=0, conflictCount=0, and the state SHALL be PRI_MEM.
REQ-031 Reset asserted mid-operation SHALL drop any write already registered for the next cycle, with no partial write.
REQ-032 Outside reset, aluReady and memReady SHALL depend only on the valids and the state; during reset both SHALL be 0.

Configuration
REQ-033 With macro WB_RR_ARB_EN defined, arbitration SHALL be round-robin per REQ-026 and REQ-027.
REQ-034 Without WB_RR_ARB_EN, the load unit SHALL always win ties, the state SHALL stay PRI_MEM, and conflictCount behaviour SHALL be unchanged.

Structure
REQ-035 A shared package SHALL hold the default widths (DATA_W, ADDR_W, CNT_W), the arbiter state typedef (PRI_MEM, PRI_ALU) and the zero-register index constant.
REQ-036 The saturating counter SHALL be the sub-module sat_counter (parameter CNT_W, inputs clock, resetN, inc, output count).
REQ-037 The block SHALL connect directly to the register file's regWrite, writeRegId and writeData inputs on the same clock.

Verification
REQ-038 Reset release, then aluValid=1, aluRegId=5, aluData=50 -> aluReady=1 the same cycle; next cycle regWrite=1, writeRegId=5, writeData=50; a subsequent read of register 5 returns 50.
REQ-039 Both valid (alu: reg 3 / 0x11, mem: reg 4 / 0x22), macro defined -> mem transfers first and ALU second on consecutive cycles; conflictCount=1.
REQ-040 Repeated ties for 4 cycles with the macro defined -> grant order mem, alu, mem, alu; without the macro -> mem is served every tie and the ALU waits.
REQ-041 memValid=1, memRegId=0, memData=0xFFFFFFFF -> memReady=1 and regWrite stays 0; register 0 still reads 0.
REQ-042 Both requests held valid for 2^CNT_W+3 cycles -> conflictCount stops at 0xFFFF.
REQ-043 resetN driven low one cycle after a transfer -> regWrite=0 immediately; conflictCount=0; the first tie after release goes to mem.
